// File: rtl/ser2par_pkg.sv
// Shared definitions for the serial link: FSM state encoding and default frame width.
// The transmitter reuses SER2PAR_DATA_W so both ends agree on framing.
package ser2par_pkg;

    localparam int unsigned SER2PAR_DATA_W = 8;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] SHIFT  = 2'd1;
    localparam logic [STATE_W-1:0] PARITY = 2'd2;
    localparam logic [STATE_W-1:0] LOAD   = 2'd3;

endpackage

// File: rtl/ser2par.sv
// Serial-to-parallel receiver for the LSB-first link; sync marks bit 0 of each frame.
// Define SER2PAR_PARITY_EN to expect one even-parity bit after the data bits.
module ser2par
    import ser2par_pkg::*;
#(
    parameter int unsigned DATA_W = SER2PAR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              sync,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  merged_c;
    logic [DATA_W-1:0]  load_word_c;
    logic               start_c;
    logic               shift_c;
    logic               load_c;
    logic               last_c;

    // Shift register with the current serial bit placed at position cnt
    always_comb begin
        merged_c = shreg;
        merged_c[cnt[IDX_W-1:0]] = sin;
    end

`ifdef SER2PAR_PARITY_EN
    assign load_word_c = shreg;
`else
    assign load_word_c = merged_c;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; sync in any state abandons the current frame and restarts
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        shift_c    = 1'b0;
        load_c     = 1'b0;
        last_c     = (cnt == LAST_CNT);
        if (sync) begin
            start_c    = 1'b1;
            state_next = SHIFT;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                SHIFT: begin
                    shift_c = 1'b1;
                    if (last_c) begin
`ifdef SER2PAR_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = LOAD;
                        load_c     = 1'b1;
`endif
                    end
                end
`ifdef SER2PAR_PARITY_EN
                PARITY: begin
                    state_next = LOAD;
                    load_c     = 1'b1;
                end
`endif
                LOAD: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Bit counter, shift register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
            dout  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            if (start_c) begin
                shreg <= {{(DATA_W-1){1'b0}}, sin};
                cnt   <= CNT_W'(1);
            end else if (shift_c) begin
                shreg <= merged_c;
                cnt   <= cnt + CNT_W'(1);
            end
            if (load_c) begin
                dout <= load_word_c;
            end
            valid <= (state_next == LOAD);
            busy  <= (state_next == SHIFT) || (state_next == PARITY);
        end
    end

`ifdef SER2PAR_PARITY_EN
    // Even parity: XOR over data and parity bit is 1 on a mismatch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (load_c) begin
            err <= (^shreg) ^ sin;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
